// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the memory controller: FSM state encodings,
// access size codes, the IO address window selector and a size decoder.
package mem_ctrl_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_IF_READ  = 2'd1;
    localparam logic [1:0] ST_LS_READ  = 2'd2;
    localparam logic [1:0] ST_LS_WRITE = 2'd3;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // addr[17:16] value that selects the IO sink window
    localparam logic [1:0] IO_ADDR_SEL = 2'b11;

    // Byte count for a size code; the reserved code 11 behaves as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and
// load/store traffic onto a single 8-bit RAM port.
// Optional feature macro: IO_BUFFER_STALL_EN -- holds stores into the IO
// window (addr[17:16]==2'b11) while io_buffer_full is high.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting; ls_req beats if_req, flush blocks acceptance
// ST_IF_READ  | 4-byte instruction fetch in flight
// ST_LS_READ  | 1/2/4-byte load in flight
// ST_LS_WRITE | 1/2/4-byte store in flight, not abortable by flush
//
// Read timing: cnt==k drives addr+k (k<n) and captures the byte addressed
// in the previous cycle into lane k-1 (k>=1); cnt==n+1 is the done cycle.
// Write timing: cnt==k (k<n) writes byte k; cnt==n is the done cycle.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_data,
    output logic        if_done,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic [31:0] ls_rdata,
    output logic        ls_done
);

    logic [1:0]  state;
    logic [2:0]  cnt;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;

    logic [2:0]  n_bytes;
    logic        is_read;
    logic        read_last;
    logic        write_last;
    logic        io_stall;
    logic        wr_active;
    logic        rd_hold;
    logic [1:0]  lane_rd;
    logic [7:0]  wr_byte;

    assign n_bytes    = size_bytes(size);
    assign is_read    = (state == ST_IF_READ) || (state == ST_LS_READ);
    assign read_last  = is_read && (cnt == n_bytes + 3'd1);
    assign write_last = (state == ST_LS_WRITE) && (cnt == n_bytes);
    assign lane_rd    = cnt[1:0] - 2'd1;

`ifdef IO_BUFFER_STALL_EN
    assign io_stall = (state == ST_LS_WRITE) && (addr[17:16] == IO_ADDR_SEL)
                      && io_buffer_full;
`else
    // Port kept for pin compatibility; it has no effect in this build.
    assign io_stall = io_buffer_full & 1'b0;
`endif

    assign wr_active = rdy && (state == ST_LS_WRITE) && (cnt < n_bytes) && !io_stall;

    // While stalled mid-read, keep presenting the in-flight byte's address so
    // mem_din still carries that byte in the first cycle after rdy returns.
    assign rd_hold = !rdy && is_read && (cnt != 3'd0);

    assign wr_byte  = wdata[{cnt[1:0], 3'b000} +: 8];
    assign mem_a    = addr + {29'd0, cnt} - {31'd0, rd_hold};
    assign mem_wr   = wr_active;
    assign mem_dout = wr_active ? wr_byte : 8'h00;

    assign if_done  = rdy && !flush && read_last && (state == ST_IF_READ);
    assign ls_done  = (rdy && !flush && read_last && (state == ST_LS_READ))
                      || (rdy && write_last);
    assign if_data  = rdata;
    assign ls_rdata = rdata;

    // Request acceptance, byte sequencing and read-lane capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
            addr  <= 32'd0;
            size  <= 2'b00;
            wdata <= 32'd0;
            rdata <= 32'd0;
        end else if (rdy) begin
            case (state)
                ST_IDLE: begin
                    if (!flush) begin
                        if (ls_req) begin
                            state <= ls_wr ? ST_LS_WRITE : ST_LS_READ;
                            addr  <= ls_addr;
                            size  <= ls_size;
                            wdata <= ls_wdata;
                            cnt   <= 3'd0;
                            rdata <= 32'd0;
                        end else if (if_req) begin
                            state <= ST_IF_READ;
                            addr  <= if_addr;
                            size  <= SIZE_WORD;
                            cnt   <= 3'd0;
                            rdata <= 32'd0;
                        end
                    end
                end
                ST_IF_READ, ST_LS_READ: begin
                    if (flush || read_last) begin
                        state <= ST_IDLE;
                        cnt   <= 3'd0;
                    end else begin
                        if (cnt != 3'd0) begin
                            rdata[{lane_rd, 3'b000} +: 8] <= mem_din;
                        end
                        cnt <= cnt + 3'd1;
                    end
                end
                ST_LS_WRITE: begin
                    if (write_last) begin
                        state <= ST_IDLE;
                        cnt   <= 3'd0;
                    end else if (!io_stall) begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

endmodule
